// File: rtl/bus_cycle_controller.sv
`timescale 1ns/1ps
// 8088 minimum-mode bus cycle controller: follows the CPU T-states, latches the
// demultiplexed address and cycle type, drives system command strobes and RDY.
module bus_cycle_controller #(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned MEM_WAIT_STATES = 0,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_clock_posedge,
    input  logic        cpu_clock_negedge,
    input  logic [19:0] ADDRESS_IN,
    input  logic        ALE,
    input  logic        RD_N,
    input  logic        WR_N,
    input  logic        IO_OR_M,
    input  logic        DT_OR_R,
    input  logic        INTA_N,
    input  logic        EXT_READY,
    output logic [19:0] ADDRESS,
    output logic        X_IO_OR_M,
    output logic        R_OR_DT,
    output logic        MEMR_N,
    output logic        MEMW_N,
    output logic        IOR_N,
    output logic        IOW_N,
    output logic        IO_E,
    output logic        RDY,
    output logic        BUS_TIMEOUT,
    output logic [2:0]  T_STATE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_TW   = 3'd4,
        S_T4   = 3'd5
    } t_state_e;

    localparam logic [3:0] IO_WAIT  = 4'(IO_WAIT_STATES);
    localparam logic [3:0] MEM_WAIT = 4'(MEM_WAIT_STATES);
    localparam logic [7:0] TIMEOUT  = 8'(TIMEOUT_CYCLES);

    t_state_e    state_q, state_d;
    logic [19:0] address_q, address_d;
    logic        x_io_q, x_io_d;
    logic        r_or_dt_q, r_or_dt_d;
    logic        memr_n_q, memr_n_d;
    logic        memw_n_q, memw_n_d;
    logic        ior_n_q, ior_n_d;
    logic        iow_n_q, iow_n_d;
    logic        io_e_q, io_e_d;
    logic        rdy_q, rdy_d;
    logic        bus_timeout_q, bus_timeout_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  timeout_cnt_q, timeout_cnt_d;

    logic timed_out;
    logic ext_ready_eff;
    logic need_wait;
    logic bus_active;
    logic cmd_state;

    always_comb begin
        // Once the watchdog has expired, external ready is ignored until the next T1->T2.
        timed_out     = (timeout_cnt_q == TIMEOUT);
        ext_ready_eff = EXT_READY | timed_out;
        need_wait     = (wait_cnt_q != 4'd0) || !ext_ready_eff;
        bus_active    = (state_q == S_T2) || (state_q == S_T3) || (state_q == S_TW);
        cmd_state     = bus_active || (state_q == S_T4);
    end

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        x_io_d        = x_io_q;
        r_or_dt_d     = r_or_dt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        bus_timeout_d = 1'b0;

        if (cpu_clock_posedge && ALE) begin
            state_d   = S_T1;
            address_d = ADDRESS_IN;
            x_io_d    = IO_OR_M | ~INTA_N;
            r_or_dt_d = ~DT_OR_R;
        end else if (cpu_clock_negedge) begin
            case (state_q)
                S_T1: begin
                    state_d       = S_T2;
                    wait_cnt_d    = x_io_q ? IO_WAIT : MEM_WAIT;
                    timeout_cnt_d = 8'd0;
                end
                S_T2: state_d = S_T3;
                S_T3, S_TW: begin
                    if (need_wait) begin
                        state_d = S_TW;
                        if (wait_cnt_q != 4'd0) begin
                            wait_cnt_d = wait_cnt_q - 4'd1;
                        end
                        if (!EXT_READY && !timed_out) begin
                            timeout_cnt_d = timeout_cnt_q + 8'd1;
                            bus_timeout_d = (timeout_cnt_q + 8'd1 == TIMEOUT);
                        end
                    end else begin
                        state_d = S_T4;
                    end
                end
                S_T4:    state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        memr_n_d = ~(cmd_state & ~RD_N & ~x_io_q);
        memw_n_d = ~(cmd_state & ~WR_N & ~x_io_q);
        ior_n_d  = ~(cmd_state & ~RD_N & x_io_q);
        iow_n_d  = ~(cmd_state & ~WR_N & x_io_q);
        io_e_d   = x_io_q & bus_active;
        rdy_d    = ~(bus_active & need_wait);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            address_q     <= 20'd0;
            x_io_q        <= 1'b0;
            r_or_dt_q     <= 1'b1;
            memr_n_q      <= 1'b1;
            memw_n_q      <= 1'b1;
            ior_n_q       <= 1'b1;
            iow_n_q       <= 1'b1;
            io_e_q        <= 1'b0;
            rdy_q         <= 1'b1;
            bus_timeout_q <= 1'b0;
            wait_cnt_q    <= 4'd0;
            timeout_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            x_io_q        <= x_io_d;
            r_or_dt_q     <= r_or_dt_d;
            memr_n_q      <= memr_n_d;
            memw_n_q      <= memw_n_d;
            ior_n_q       <= ior_n_d;
            iow_n_q       <= iow_n_d;
            io_e_q        <= io_e_d;
            rdy_q         <= rdy_d;
            bus_timeout_q <= bus_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign ADDRESS     = address_q;
    assign X_IO_OR_M   = x_io_q;
    assign R_OR_DT     = r_or_dt_q;
    assign MEMR_N      = memr_n_q;
    assign MEMW_N      = memw_n_q;
    assign IOR_N       = ior_n_q;
    assign IOW_N       = iow_n_q;
    assign IO_E        = io_e_q;
    assign RDY         = rdy_q;
    assign BUS_TIMEOUT = bus_timeout_q;
    assign T_STATE     = state_q;

endmodule
